// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared definitions for the HD44780 panel-side responder: DDRAM map, opcode classes
// and small address/shift helpers.
package lcd_hd44780_responder_pkg;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE1_LAST = 7'h27;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE2_LAST = 7'h67;
   localparam int         LINE_LEN   = 40;
   localparam int         DDRAM_SIZE = 80;
   localparam logic [7:0] BLANK      = 8'h20;

   typedef enum logic [3:0] {
      INS_NOP,
      INS_CLEAR,
      INS_HOME,
      INS_ENTRY,
      INS_DISPLAY,
      INS_SHIFT,
      INS_FUNC,
      INS_CGRAM,
      INS_DDRAM
   } instr_e;

   // The instruction class is selected by the highest set bit of the opcode byte.
   function automatic instr_e decode_instr(input logic [7:0] d);
      if (d[7])      return INS_DDRAM;
      else if (d[6]) return INS_CGRAM;
      else if (d[5]) return INS_FUNC;
      else if (d[4]) return INS_SHIFT;
      else if (d[3]) return INS_DISPLAY;
      else if (d[2]) return INS_ENTRY;
      else if (d[1]) return INS_HOME;
      else if (d[0]) return INS_CLEAR;
      else           return INS_NOP;
   endfunction

   function automatic logic addr_legal(input logic [6:0] a);
      return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
   endfunction

   // Line 2 is packed directly after line 1 in the 80-byte array.
   function automatic logic [6:0] ddram_idx(input logic [6:0] a);
      if (a <= LINE1_LAST)
         return a;
      else if ((a >= LINE2_BASE) && (a <= LINE2_LAST))
         return a - LINE2_BASE + 7'(LINE_LEN);
      else
         return 7'd0;
   endfunction

   function automatic logic [5:0] shift_step(input logic [5:0] s, input logic dir);
      if (dir)
         return (s == 6'(LINE_LEN - 1)) ? 6'd0 : s + 6'd1;
      else
         return (s == 6'd0) ? 6'(LINE_LEN - 1) : s - 6'd1;
   endfunction

endpackage

// File: rtl/lcd_hd44780_responder_ac_step.sv
// Address-counter step with 2-line DDRAM wrap: 0x27<->0x40 and 0x67<->0x00.
module lcd_hd44780_responder_ac_step
   import lcd_hd44780_responder_pkg::*;
(
   input  logic [6:0] ac,
   input  logic       dir,
   output logic [6:0] ac_next
);

   always_comb begin
      ac_next = ac;
      if (dir) begin
         if (ac == LINE1_LAST)      ac_next = LINE2_BASE;
         else if (ac == LINE2_LAST) ac_next = LINE1_BASE;
         else                       ac_next = ac + 7'd1;
      end else begin
         if (ac == LINE1_BASE)      ac_next = LINE2_LAST;
         else if (ac == LINE2_BASE) ac_next = LINE1_LAST;
         else                       ac_next = ac - 7'd1;
      end
   end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel end of the HD44780 8-bit bus: decodes transfers on the falling edge of E,
// holds DDRAM/AC/display flags, models busy time and answers status/data reads.
module lcd_hd44780_responder
   import lcd_hd44780_responder_pkg::*;
#(
   parameter int EXEC_CYCLES  = 4,
   parameter int CLEAR_CYCLES = 153
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_data,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       busy,
   output logic       proto_err
);

   localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

   logic             e_q, rs_q, rw_q;
   logic [7:0]       d_q;
   logic [6:0]       ac;
   logic             id, s;
   logic [5:0]       shift;
   logic             cgram_mode;
   logic [CNT_W-1:0] busy_cnt;
   logic [7:0]       ddram [DDRAM_SIZE];

   logic             commit, wr_ok, step_dir;
   logic [6:0]       ac_next;
   instr_e           kind;

   assign commit = e_q & ~lcd_e;
   assign busy   = (busy_cnt != '0);
   assign wr_ok  = commit & ~rw_q & ~busy;
   assign kind   = decode_instr(d_q);

   // Cursor-shift instructions step by R/L; everything else follows the entry-mode I/D bit.
   assign step_dir = (!rs_q && kind == INS_SHIFT) ? d_q[2] : id;

   lcd_hd44780_responder_ac_step u_ac_step (
      .ac      (ac),
      .dir     (step_dir),
      .ac_next (ac_next)
   );

   always_ff @(posedge clk) begin
      d_q <= lcd_data_in;
      if (!reset) begin
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         ac         <= LINE1_BASE;
         id         <= 1'b1;
         s          <= 1'b0;
         shift      <= 6'd0;
         disp_on    <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         cgram_mode <= 1'b0;
         busy_cnt   <= '0;
         proto_err  <= 1'b0;
         for (int i = 0; i < DDRAM_SIZE; i++) ddram[i] <= BLANK;
      end else begin
         e_q  <= lcd_e;
         rs_q <= lcd_rs;
         rw_q <= lcd_rw;

         if (busy) busy_cnt <= busy_cnt - CNT_W'(1);

         // A rejected write leaves the running busy countdown untouched.
         if (commit && !rw_q && busy) proto_err <= 1'b1;

         if (wr_ok) begin
            if (!rs_q && (kind == INS_CLEAR || kind == INS_HOME))
               busy_cnt <= CNT_W'(CLEAR_CYCLES);
            else
               busy_cnt <= CNT_W'(EXEC_CYCLES);

            if (rs_q) begin
               if (!cgram_mode) begin
                  ddram[ddram_idx(ac)] <= d_q;
                  ac                   <= ac_next;
                  if (s) shift <= shift_step(shift, id);
               end
            end else begin
               case (kind)
                  INS_CLEAR: begin
                     for (int i = 0; i < DDRAM_SIZE; i++) ddram[i] <= BLANK;
                     ac    <= LINE1_BASE;
                     id    <= 1'b1;
                     shift <= 6'd0;
                  end
                  INS_HOME: begin
                     ac    <= LINE1_BASE;
                     shift <= 6'd0;
                  end
                  INS_ENTRY: begin
                     id <= d_q[1];
                     s  <= d_q[0];
                  end
                  INS_DISPLAY: begin
                     disp_on   <= d_q[2];
                     cursor_on <= d_q[1];
                     blink_on  <= d_q[0];
                  end
                  INS_SHIFT: begin
                     if (d_q[3]) shift <= shift_step(shift, d_q[2]);
                     else        ac    <= ac_next;
                  end
                  INS_CGRAM: cgram_mode <= 1'b1;
                  INS_DDRAM: begin
                     cgram_mode <= 1'b0;
                     if (addr_legal(d_q[6:0])) ac        <= d_q[6:0];
                     else                      proto_err <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         if (commit && rw_q && rs_q) ac <= ac_next;
      end
   end

   assign lcd_data_oe = rw_q & e_q;

   always_comb begin
      lcd_data_out = 8'h00;
      if (e_q && rw_q)
         lcd_data_out = rs_q ? ddram[ddram_idx(ac)] : {busy, ac};
   end

   assign dbg_data = addr_legal(dbg_addr) ? ddram[ddram_idx(dbg_addr)] : 8'h00;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed scoreboard bench for lcd_hd44780_responder: bus reads and state probes are
// queued with hand-computed expectations and checked by an independent monitor.
module tb_lcd_hd44780_responder;
   localparam int EXEC  = 4;
   localparam int CLEAR = 153;

   localparam logic [23:0] M_DBG   = 24'h0000FF;
   localparam logic [23:0] M_OE    = 24'h000100;
   localparam logic [23:0] M_FLAGS = 24'h000E00;
   localparam logic [23:0] M_BUSY  = 24'h001000;
   localparam logic [23:0] M_PERR  = 24'h002000;
   localparam logic [23:0] M_ALL   = 24'hFF3FFF;

   logic       clk, reset, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data_in, lcd_data_out, dbg_data;
   logic       lcd_data_oe, disp_on, cursor_on, blink_on, busy, proto_err;
   logic [6:0] dbg_addr;
   logic       probe_vld;

   typedef struct {
      string       name;
      logic [7:0]  exp;
   } bus_t;
   typedef struct {
      string       name;
      logic [23:0] exp;
      logic [23:0] mask;
   } probe_t;

   bus_t   bus_q[$];
   probe_t probe_q[$];
   int     errors = 0;
   int     checks = 0;

   lcd_hd44780_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR)) dut (
      .clk          (clk),
      .reset        (reset),
      .lcd_e        (lcd_e),
      .lcd_rs       (lcd_rs),
      .lcd_rw       (lcd_rw),
      .lcd_data_in  (lcd_data_in),
      .lcd_data_out (lcd_data_out),
      .lcd_data_oe  (lcd_data_oe),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .disp_on      (disp_on),
      .cursor_on    (cursor_on),
      .blink_on     (blink_on),
      .busy         (busy),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] pv(input logic perr, input logic bsy, input logic d,
                                      input logic c, input logic b, input logic oe,
                                      input logic [7:0] out, input logic [7:0] dbg);
      return {out, 2'b00, perr, bsy, d, c, b, oe, dbg};
   endfunction

   // Monitor: pops a bus expectation on each read strobe, a probe expectation on probe_vld.
   initial begin
      logic        oe_prev;
      logic [23:0] act;
      bus_t        be;
      probe_t      pe;
      oe_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (lcd_data_oe && !oe_prev) begin
            checks++;
            if (bus_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_read: got %h required no read", lcd_data_out);
            end else begin
               be = bus_q.pop_front();
               if (lcd_data_out !== be.exp) begin
                  errors++;
                  $display("FAIL %s: got %h required %h", be.name, lcd_data_out, be.exp);
               end
            end
         end
         oe_prev = lcd_data_oe;
         if (probe_vld) begin
            checks++;
            act = pv(proto_err, busy, disp_on, cursor_on, blink_on, lcd_data_oe,
                     lcd_data_out, dbg_data);
            if (probe_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_probe: got %h", act);
            end else begin
               pe = probe_q.pop_front();
               if ((act & pe.mask) !== (pe.exp & pe.mask)) begin
                  errors++;
                  $display("FAIL %s: got %h required %h (mask %h)", pe.name,
                           act & pe.mask, pe.exp & pe.mask, pe.mask);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
      lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
      tick(2);
      lcd_e = 1'b0;
      tick(1);
   endtask

   task automatic cmd(input logic [7:0] d);
      xfer(1'b0, 1'b0, d);
      if (d == 8'h01 || d[7:1] == 7'h01) tick(CLEAR + 6);
      else                               tick(EXEC + 2);
   endtask

   task automatic wdata(input logic [7:0] d);
      xfer(1'b1, 1'b0, d);
      tick(EXEC + 2);
   endtask

   task automatic rd(input string name, input logic rs, input logic [7:0] exp);
      bus_t b;
      b.name = name; b.exp = exp;
      bus_q.push_back(b);
      xfer(rs, 1'b1, 8'h00);
   endtask

   task automatic probe(input string name, input logic [6:0] addr,
                        input logic [23:0] exp, input logic [23:0] mask);
      probe_t p;
      p.name = name; p.exp = exp; p.mask = mask;
      probe_q.push_back(p);
      dbg_addr  = addr;
      probe_vld = 1'b1;
      tick(1);
      probe_vld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
      lcd_data_in = 8'h00; dbg_addr = 7'h00; probe_vld = 1'b0;
      tick(3);
      probe("reset_state", 7'h00, pv(0,0,0,0,0,0,8'h00,8'h20), M_ALL);
      reset = 1'b1;
      tick(1);

      // Init sequence
      cmd(8'h38); cmd(8'h0C); cmd(8'h06); cmd(8'h01);
      probe("init_state", 7'h00, pv(0,0,1,0,0,0,8'h00,8'h20), M_ALL);
      probe("init_blank_67", 7'h67, pv(0,0,0,0,0,0,8'h00,8'h20), M_DBG);
      rd("init_status", 1'b0, 8'h00);

      // Line-1 to line-2 wrap on increment
      cmd(8'hA7); wdata(8'h41); wdata(8'h42);
      probe("ddram_27", 7'h27, pv(0,0,0,0,0,0,8'h00,8'h41), M_DBG);
      probe("ddram_40", 7'h40, pv(0,0,0,0,0,0,8'h00,8'h42), M_DBG);
      probe("dbg_unmapped", 7'h30, pv(0,0,0,0,0,0,8'h00,8'h00), M_DBG);
      rd("status_after_wrap", 1'b0, 8'h41);

      // Decrement wrap 0x00 -> 0x67, cursor shift both ways
      cmd(8'h04); cmd(8'h80); wdata(8'h5A);
      probe("ddram_00", 7'h00, pv(0,0,0,0,0,0,8'h00,8'h5A), M_DBG);
      rd("status_dec_wrap", 1'b0, 8'h67);
      cmd(8'h14);
      rd("status_shift_right", 1'b0, 8'h00);
      cmd(8'h10);
      rd("status_shift_left", 1'b0, 8'h67);
      cmd(8'h0F);
      probe("flags_dcb", 7'h00, pv(0,0,1,1,1,0,8'h00,8'h00), M_FLAGS);

      // CGRAM mode discards data writes
      cmd(8'h40); wdata(8'h55);
      rd("status_cgram", 1'b0, 8'h67);
      probe("cgram_no_write", 7'h67, pv(0,0,0,0,0,0,8'h00,8'h20), M_DBG);

      // Clear busy time is exactly CLEAR cycles
      xfer(1'b0, 1'b0, 8'h01);
      probe("busy_first", 7'h00, pv(0,1,0,0,0,0,8'h00,8'h00), M_BUSY);
      tick(CLEAR - 2);
      probe("busy_last", 7'h00, pv(0,1,0,0,0,0,8'h00,8'h00), M_BUSY);
      probe("busy_fell", 7'h00, pv(0,0,0,0,0,0,8'h00,8'h00), M_BUSY | M_PERR);

      // Status read and rejected write while busy
      xfer(1'b0, 1'b0, 8'h01);
      rd("status_busy", 1'b0, 8'h80);
      xfer(1'b1, 1'b0, 8'h51);
      tick(CLEAR + 6);
      probe("write_while_busy", 7'h00, pv(1,0,0,0,0,0,8'h00,8'h20), M_DBG | M_PERR | M_BUSY);
      rd("status_after_reject", 1'b0, 8'h00);

      reset = 1'b0; tick(1); reset = 1'b1; tick(1);

      // Illegal DDRAM address and data read
      cmd(8'hC0); wdata(8'h4B); cmd(8'hC0);
      probe("perr_clear", 7'h40, pv(0,0,0,0,0,0,8'h00,8'h4B), M_PERR | M_DBG);
      cmd(8'hA8);
      probe("perr_illegal", 7'h40, pv(1,0,0,0,0,0,8'h00,8'h00), M_PERR);
      rd("status_illegal", 1'b0, 8'h40);
      rd("data_read", 1'b1, 8'h4B);
      rd("status_after_read", 1'b0, 8'h41);

      // Reset in the middle of a write, with busy and flags set
      xfer(1'b0, 1'b0, 8'h0F);
      lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h58; lcd_e = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      probe("reset_mid_write", 7'h40, pv(0,0,0,0,0,0,8'h00,8'h20), M_ALL);
      lcd_e = 1'b0; reset = 1'b1;
      tick(1);
      probe("no_commit_after_reset", 7'h41, pv(0,0,0,0,0,0,8'h00,8'h20), M_ALL);
      rd("status_after_reset", 1'b0, 8'h00);

      tick(5);
      checks++;
      if (bus_q.size() != 0 || probe_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: got %0d bus %0d probe required 0 0",
                  bus_q.size(), probe_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
